// File: rtl/onehot_enc_pkg.sv
// onehot_enc_pkg
//   Shared constants for the one-hot encoder pipeline:
//   - N_DEFAULT / CNT_W_DEFAULT : default input width and error counter width
//   - clog2()                   : constant-evaluable ceiling log2 for port sizing
//   - err_reason_e              : why an accepted word was flagged; only a single
//                                 error bit leaves the top level
//   Config macro: ONEHOT_PRIORITY_EN (consumed by onehot_enc_core).
package onehot_enc_pkg;

    localparam int N_DEFAULT     = 10;
    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ZERO  = 2'd1,
        ERR_MULTI = 2'd2
    } err_reason_e;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = int'(i) + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_enc_core.sv
// onehot_enc_core
//   Purely combinational N-to-W one-hot encoder with zero-hot / multi-hot detection.
//   Config macro: ONEHOT_PRIORITY_EN
//     defined   : multi-hot words encode to the highest set bit, no error
//     undefined : multi-hot words encode to 0 and report ERR_MULTI
//   An all-zero word always encodes to 0 and reports ERR_ZERO.
//   Ports:
//     i_data   [N-1:0]  one-hot input word
//     o_code   [W-1:0]  binary index of the set bit
//     o_reason          error reason (ERR_NONE / ERR_ZERO / ERR_MULTI)
module onehot_enc_core
    import onehot_enc_pkg::*;
#(
    parameter  int N = N_DEFAULT,
    localparam int W = clog2(N)
) (
    input  logic [N-1:0] i_data,
    output logic [W-1:0] o_code,
    output err_reason_e  o_reason
);

    logic [W-1:0] w_high;
    logic         w_zero;

    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        w_high = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_data[i]) begin
                w_high = W'(i);
            end
        end
    end

    assign w_zero = (i_data == '0);

`ifdef ONEHOT_PRIORITY_EN
    always_comb begin
        o_code   = '0;
        o_reason = ERR_NONE;
        if (w_zero) begin
            o_reason = ERR_ZERO;
        end else begin
            o_code = w_high;
        end
    end
`else
    logic w_multi;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(i_data & (i_data - {{(N-1){1'b0}}, 1'b1}));

    always_comb begin
        o_code   = '0;
        o_reason = ERR_NONE;
        if (w_zero) begin
            o_reason = ERR_ZERO;
        end else if (w_multi) begin
            o_reason = ERR_MULTI;
        end else begin
            o_code = w_high;
        end
    end
`endif

endmodule

// File: rtl/onehot_encoder_pipe.sv
// onehot_encoder_pipe
//   Registered one-hot-to-binary encoder with valid/ready on both sides and a
//   saturating count of illegal words. Encoding lives in onehot_enc_core; this
//   level holds the output register, the handshake and the counter.
//   Config macro: ONEHOT_PRIORITY_EN (multi-hot handling, see onehot_enc_core).
//   Ports:
//     i_clk, i_rst_n      clock, synchronous active-low reset
//     i_in_valid/o_in_ready/i_in_data      input handshake and N-bit word
//     o_out_valid/i_out_ready              output handshake
//     o_out_code [W-1:0]  binary index,  o_out_err  word was illegal
//     o_err_count [CNT_W-1:0] saturating error count, i_clr_count clears it
module onehot_encoder_pipe
    import onehot_enc_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    parameter  int CNT_W = CNT_W_DEFAULT,
    localparam int W     = clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [N-1:0]     i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [W-1:0]     o_out_code,
    output logic             o_out_err,
    output logic [CNT_W-1:0] o_err_count,
    input  logic             i_clr_count
);

    logic [W-1:0]     w_code;
    err_reason_e      w_reason;
    logic             w_err;
    logic             w_accept;

    logic             r_valid;
    logic [W-1:0]     r_code;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    onehot_enc_core #(
        .N (N)
    ) u_core (
        .i_data   (i_in_data),
        .o_code   (w_code),
        .o_reason (w_reason)
    );

    assign w_err      = (w_reason != ERR_NONE);
    // Output register is free when empty or being drained this cycle.
    assign o_in_ready = !r_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_code  <= w_code;
            r_err   <= w_err;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr_count) begin
            r_cnt <= '0;
        end else if (w_accept && w_err && (r_cnt != '1)) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_code  = r_code;
    assign o_out_err   = r_err;
    assign o_err_count = r_cnt;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// tb_onehot_encoder_pipe
//   Drives two instances (CNT_W = 8 and CNT_W = 2) with shared stimulus and
//   compares against a cycle-level reference model of the handshake, the
//   encoding rules and both saturating counters.
module tb_onehot_encoder_pipe;

    localparam int N = 10;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_ready;
    logic         clr_count;

    logic         in_ready_a, out_valid_a, out_err_a;
    logic [3:0]   out_code_a;
    logic [7:0]   err_count_a;
    logic         in_ready_b, out_valid_b, out_err_b;
    logic [3:0]   out_code_b;
    logic [1:0]   err_count_b;

    int n_vec;
    int n_fail;

    // reference model state
    bit       m_valid;
    int       m_code;
    bit       m_err;
    int       m_cnt8;
    int       m_cnt2;

    onehot_encoder_pipe #(.N(N), .CNT_W(8)) dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready_a),
        .i_in_data   (in_data),
        .o_out_valid (out_valid_a),
        .i_out_ready (out_ready),
        .o_out_code  (out_code_a),
        .o_out_err   (out_err_a),
        .o_err_count (err_count_a),
        .i_clr_count (clr_count)
    );

    onehot_encoder_pipe #(.N(N), .CNT_W(2)) dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready_b),
        .i_in_data   (in_data),
        .o_out_valid (out_valid_b),
        .i_out_ready (out_ready),
        .o_out_code  (out_code_b),
        .o_out_err   (out_err_b),
        .o_err_count (err_count_b),
        .i_clr_count (clr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Encoding rules stated directly: count the set bits, locate the top one.
    task automatic ref_encode(input logic [N-1:0] d, output int code, output bit err);
        int ones;
        int top;
        ones = 0;
        top  = 0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                ones++;
                top = i;
            end
        end
        if (ones == 0) begin
            code = 0; err = 1'b1;
        end else if (ones == 1) begin
            code = top; err = 1'b0;
        end else begin
`ifdef ONEHOT_PRIORITY_EN
            code = top; err = 1'b0;
`else
            code = 0; err = 1'b1;
`endif
        end
    endtask

    // One clock: apply inputs, check the combinational ready, advance model
    // at the edge, then check registered outputs half a cycle later.
    task automatic step(input bit rst, input bit v, input logic [N-1:0] d,
                        input bit ordy, input bit clr);
        bit acc;
        int c;
        bit e;
        rst_n     = !rst;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clr_count = clr;
        #1;
        check_eq("in_ready_a", int'(in_ready_a), int'(!m_valid || ordy));
        check_eq("in_ready_b", int'(in_ready_b), int'(!m_valid || ordy));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_code = 0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            acc = v && (!m_valid || ordy);
            ref_encode(d, c, e);
            if (clr) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else if (acc && e) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
            if (acc) begin
                m_valid = 1'b1; m_code = c; m_err = e;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("out_valid", int'(out_valid_a), int'(m_valid));
        check_eq("out_code",  int'(out_code_a),  m_code);
        check_eq("out_err",   int'(out_err_a),   int'(m_err));
        check_eq("err_cnt8",  int'(err_count_a), m_cnt8);
        check_eq("out_valid_b", int'(out_valid_b), int'(m_valid));
        check_eq("out_code_b",  int'(out_code_b),  m_code);
        check_eq("err_cnt2",  int'(err_count_b), m_cnt2);
    endtask

    function automatic logic [N-1:0] rand_word();
        int sel;
        logic [N-1:0] w;
        sel = int'($urandom_range(0, 9));
        if (sel < 5) begin
            w = '0;
            w[$urandom_range(0, N-1)] = 1'b1;
        end else if (sel == 5) begin
            w = '0;
        end else begin
            w = N'($urandom);
        end
        return w;
    endfunction

    initial begin
        n_vec = 0; n_fail = 0;
        m_valid = 1'b0; m_code = 0; m_err = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_count = 1'b0;
        @(negedge clk);

        // reset with garbage on the inputs
        step(1, 1, 10'h3ff, 0, 0);
        step(1, 0, 10'h000, 1, 0);

        // sweep of single-bit words, back-to-back
        for (int k = 0; k < N; k++) begin
            step(0, 1, 10'(1) << k, 1, 0);
        end
        // zero word, then multi-hot
        step(0, 1, 10'h000, 1, 0);
        step(0, 1, 10'b0000100100, 1, 0);
        step(0, 0, 10'h000, 1, 0);

        // backpressure: result 3 must hold while the sink stalls
        step(0, 1, 10'h008, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 10'h040, 0, 0);
            check_eq("stall_code", int'(out_code_a), 3);
        end
        step(0, 1, 10'h040, 1, 0);
        check_eq("after_stall_code", int'(out_code_a), 6);
        step(0, 0, 10'h000, 1, 0);

        // saturation of the narrow counter, then clear racing an error
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 10'h000, 1, 0);
        end
        check_eq("sat_cnt2", int'(err_count_b), 3);
        step(0, 1, 10'h000, 1, 1);
        check_eq("clr_cnt2", int'(err_count_b), 0);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            step(0, $urandom_range(0, 3) != 0, rand_word(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
        end

        // reset while a result is pending and stalled
        step(0, 1, 10'h010, 0, 0);
        step(0, 1, 10'h020, 0, 0);
        step(1, 1, 10'h020, 0, 0);
        check_eq("rst_valid", int'(out_valid_a), 0);
        step(0, 0, 10'h000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot_encoder_pipe.md
# onehot_encoder_pipe

Parametrised, registered one-hot-to-binary encoder with valid/ready handshakes on both sides. It is the successor to the fixed 10-to-4 decimal-to-binary encoder. Width is generic, the output is registered with backpressure, invalid inputs (zero-hot or multi-hot) are flagged, and a saturating error counter is kept. It sits between a one-hot source (key scanner, arbiter grant, decoder) and binary-consuming logic.

## Interface
- N, default 10: input vector width; must be ≥ 2.
- CNT_W, default 8: width of the error counter.
- Derived localparam W = $clog2(N); W = 4 for N = 10.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  N  one-hot input word.
- out_valid  out  1  out_code and out_err are valid.
- out_ready  in  1  sink accepts the output this cycle.
- out_code  out  W  binary index of the set bit.
- out_err  out  1  the accepted word was not a legal encoding.
- err_count  out  CNT_W  saturating count of accepted words with errors.
- clr_count  in  1  synchronous clear of err_count.

## Operation
- Encoding, with exactly one bit k set: out_code = k, out_err = 0.
- Encoding, all-zero input: out_code = 0, out_err = 1.
- Encoding, multi-hot input: see Configuration.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, giving full throughput of one word per cycle.
- On accept: out_code and out_err are registered and out_valid is set to 1.
- If out_valid && out_ready and no new accept occurs, out_valid clears to 0.
- Stall: while out_valid && !out_ready, out_code and out_err hold stable and in_ready = 0.
- in_data is ignored whenever in_valid = 0.
- err_count:
  - Increments by 1 on each accept whose out_err = 1.
  - Saturates at 2^CNT_W − 1.
  - clr_count = 1 forces it to 0 next cycle and takes priority over a same-cycle increment.

## Timing
- Reset: on the first rising edge with rst_n = 0, out_valid = 0, out_code = 0, out_err = 0, err_count = 0.
- During reset, in_ready follows its equation, so it reads 1.
- Latency: the word accepted at edge t is visible on out_code/out_err after edge t; out_valid = 1 in the following cycle.
- Back-to-back: with out_ready held at 1, one result is produced per cycle with no bubbles.
- Simultaneous output drain and new input accept: the output register is reloaded and out_valid stays 1.
- Reset asserted mid-transfer drops any pending output; nothing is replayed.

## Configuration
- Macro: ONEHOT_PRIORITY_EN.
- Defined (priority mode):
  - Multi-hot input: out_code = index of the highest set bit, out_err = 0, counter not incremented.
  - All-zero input is still an error.
- Undefined (strict mode):
  - Multi-hot input: out_code = 0, out_err = 1, err_count increments.

## Structure
- Shared package onehot_enc_pkg contains:
  - Default N and CNT_W constants.
  - A clog2 helper function.
  - The error-reason encoding constants: ERR_NONE, ERR_ZERO, ERR_MULTI. These are for bench reporting; only a single err bit is exported.
- Sub-module onehot_enc_core: purely combinational N-to-W encoder with zero/multi-hot detection. It is parametrised by N and honours ONEHOT_PRIORITY_EN.
- The top level holds only the output register, the handshake logic and the counter.

## Test plan
- Sweep, N = 10, out_ready = 1: in_data = 1, 2, 4, … 512, one per cycle → out_code = 0…9 on consecutive cycles, out_err = 0, err_count = 0.
- Zero input: in_data = 0 (the truncated 1024 case) → out_code = 0, out_err = 1, err_count = 1.
- Multi-hot: in_data = 10'b0000100100.
  - Strict → out_code = 0, out_err = 1, err_count +1.
  - Priority → out_code = 5, out_err = 0, err_count unchanged.
- Backpressure: hold out_ready = 0 for 3 cycles after accepting 10'h008 → out_code stays 3, in_ready = 0, a new in_data is not accepted; raise out_ready → the next word follows one cycle later.
- Counter: CNT_W = 2, feed 5 zero inputs → err_count = 3 (saturated); then assert clr_count together with another error input → err_count = 0.
- Reset: pull rst_n low while out_valid = 1 → after one edge, out_valid = 0, out_code = 0, err_count = 0, in_ready = 1.
